// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states, ALU and
// condition codes, datapath source selects, and the per-state control decode.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_RESULT    = 1'b1;
  localparam logic [1:0] SRCA_REG      = 2'b00;
  localparam logic [1:0] SRCA_PC       = 2'b01;
  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
  } ctrl_t;

  // Raw Moore outputs of each state, before any condition gating.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.adrsrc    = ADR_PC;
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALURESULT;
        c.nextpc    = 1'b1;
      end
      DECODE: begin
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALURESULT;
      end
      MEMADR:   c.alusrcb = SRCB_IMM;
      MEMRD:    c.adrsrc  = ADR_RESULT;
      MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regw      = 1'b1;
      end
      MEMWR: begin
        c.adrsrc = ADR_RESULT;
        c.memw   = 1'b1;
      end
      EXECUTER: c.aluop = 1'b1;
      EXECUTEI: begin
        c.alusrcb = SRCB_IMM;
        c.aluop   = 1'b1;
      end
      ALUWB:    c.regw = 1'b1;
      BRANCH: begin
        c.alusrcb   = SRCB_IMM;
        c.resultsrc = RES_ALURESULT;
        c.branch    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_cond.sv
// Condition-code evaluator: decides from the 4-bit condition field and the
// stored {N,Z,C,V} flags whether the current instruction executes.
module cond_check
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore FSM with registered state outputs,
// condition gating and flag register. MULTICYCLE_CONTROLLER_CMP_EN adds CMP.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  logic       cond_ex;
  logic [3:0] cmd;
  logic [1:0] alu_dec;
  logic       nowrite;
  logic       cv_op;
  logic       flag_upd;

  assign cmd = Funct[4:1];

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  always_comb begin
    alu_dec = ALU_ADD;
    nowrite = 1'b0;
    cv_op   = 1'b0;
    case (cmd)
      CMD_ADD: begin
        alu_dec = ALU_ADD;
        cv_op   = 1'b1;
      end
      CMD_SUB: begin
        alu_dec = ALU_SUB;
        cv_op   = 1'b1;
      end
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
`ifdef MULTICYCLE_CONTROLLER_CMP_EN
      CMD_CMP: begin
        alu_dec = ALU_SUB;
        cv_op   = 1'b1;
        nowrite = 1'b1;
      end
`endif
      default: alu_dec = ALU_ADD;
    endcase
  end

  // CMP exists only to set flags, so it updates them even without the S bit.
  assign flag_upd = ((state_q == EXECUTER) || (state_q == EXECUTEI)) &&
                    condex_q && (Funct[0] || nowrite);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase

    ctrl_d   = state_ctrl(state_d);
    condex_d = (state_q == DECODE) ? cond_ex : condex_q;

    flags_d = flags_q;
    if (flag_upd) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (cv_op) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      ctrl_q   <= state_ctrl(FETCH);
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  assign IRWrite    = ctrl_q.irwrite;
  assign AdrSrc     = ctrl_q.adrsrc;
  assign ALUSrcA    = ctrl_q.alusrca;
  assign ALUSrcB    = ctrl_q.alusrcb;
  assign ResultSrc  = ctrl_q.resultsrc;
  assign ALUControl = ctrl_q.aluop ? alu_dec : ALU_ADD;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == OP_MEM), (Op == OP_BR)};

  assign PCWrite  = ctrl_q.nextpc |
                    (condex_q & (ctrl_q.branch | (ctrl_q.regw & (Rd == 4'hF))));
  assign RegWrite = ctrl_q.regw & condex_q & ~nowrite;
  assign MemWrite = ctrl_q.memw & condex_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions push the
// expected per-cycle control vectors; a negedge monitor pops and compares them.
module tb_multicycle_controller;

  logic       clk;
  logic       reset_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  typedef enum {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                S_EXECR, S_EXECI, S_ALUWB, S_BRANCH} st_e;

  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] act_vec();
    return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
            ALUSrcB, ResultSrc, ImmSrc, ALUControl};
  endfunction

  // Expected output vector for one state; taken/nowr/aluc are hand-computed per instruction.
  function automatic logic [16:0] model(st_e st, logic [1:0] op, logic [1:0] aluc,
                                        logic taken, logic nowr, logic [3:0] rd);
    logic pcw, mw, rw, irw, adr;
    logic [1:0] sa, sb, rs, ac;
    {pcw, mw, rw, irw, adr} = 5'b0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00; ac = 2'b00;
    case (st)
      S_FETCH:  begin irw = 1'b1; pcw = 1'b1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      S_DECODE: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      S_MEMADR: sb = 2'b01;
      S_MEMRD:  adr = 1'b1;
      S_MEMWB:  begin rs = 2'b01; rw = taken; pcw = taken && (rd == 4'hF); end
      S_MEMWR:  begin adr = 1'b1; mw = taken; end
      S_EXECR:  ac = aluc;
      S_EXECI:  begin sb = 2'b01; ac = aluc; end
      S_ALUWB:  begin rw = taken && !nowr; pcw = taken && (rd == 4'hF); end
      S_BRANCH: begin sb = 2'b01; rs = 2'b10; pcw = taken; end
      default: ;
    endcase
    return {pcw, mw, rw, irw, adr, (op == 2'b01), (op == 2'b10), sa, sb, rs, op, ac};
  endfunction

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, act_vec(), e.v);
    end
  end

  // Called right after a posedge while the DUT sits in FETCH.
  task automatic run_instr(input string nm, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic [3:0] cond,
                           input logic [3:0] flg, input logic [1:0] aluc,
                           input logic taken, input logic nowr, input int stop_at);
    st_e  path[$];
    exp_t e;
    int   nwait;
    Op = op; Funct = funct; Rd = rd; Cond = cond; ALUFlags = flg;
    path.push_back(S_FETCH);
    path.push_back(S_DECODE);
    case (op)
      2'b00: begin path.push_back(funct[5] ? S_EXECI : S_EXECR); path.push_back(S_ALUWB); end
      2'b01: begin
        path.push_back(S_MEMADR);
        if (funct[0]) begin path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
        else path.push_back(S_MEMWR);
      end
      2'b10: path.push_back(S_BRANCH);
      default: ;
    endcase
    if (stop_at > 0) while (path.size() > stop_at) void'(path.pop_back());
    foreach (path[i]) begin
      e.name = $sformatf("%s/%s", nm, path[i].name());
      e.v    = model(path[i], op, aluc, taken, nowr, rd);
      exp_q.push_back(e);
    end
    nwait = (stop_at > 0) ? path.size() - 1 : path.size();
    repeat (nwait) @(posedge clk);
    #1;
  endtask

  // Entered with reset_n already low; leaves the DUT in FETCH just after a posedge.
  task automatic hold_reset(input string nm);
    exp_t e;
    @(posedge clk); #1;
    e.name = nm;
    e.v    = model(S_FETCH, Op, 2'b00, 1'b0, 1'b0, 4'h0);
    exp_q.push_back(e);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    Op = 2'b00; Funct = 6'b0; Rd = 4'h0; Cond = 4'hE; ALUFlags = 4'h0;
    @(posedge clk);
    hold_reset("reset_fetch");

    //        name      Op     Funct      Rd    Cond   ALUFlags aluc  taken nowr stop
    run_instr("add_r1", 2'b00, 6'b001000, 4'h1, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("ldr",    2'b01, 6'b011001, 4'h2, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("str",    2'b01, 6'b011000, 4'h2, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("subs_z", 2'b00, 6'b000101, 4'h3, 4'hE, 4'h4, 2'b01, 1'b1, 1'b0, 0);
    run_instr("beq_t",  2'b10, 6'b000000, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("subs_0", 2'b00, 6'b000101, 4'h3, 4'hE, 4'h0, 2'b01, 1'b1, 1'b0, 0);
    run_instr("beq_nt", 2'b10, 6'b000000, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 0);
    run_instr("addseq", 2'b00, 6'b001001, 4'h1, 4'h0, 4'hF, 2'b00, 1'b0, 1'b0, 0);
    run_instr("bne_t",  2'b10, 6'b000000, 4'h0, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("add_pc", 2'b00, 6'b001000, 4'hF, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("addi",   2'b00, 6'b101000, 4'h4, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("orri",   2'b00, 6'b111000, 4'h4, 4'hE, 4'h0, 2'b11, 1'b1, 1'b0, 0);
    run_instr("and",    2'b00, 6'b000000, 4'h5, 4'hE, 4'h0, 2'b10, 1'b1, 1'b0, 0);
    run_instr("eor",    2'b00, 6'b000010, 4'h5, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("subs_cv",2'b00, 6'b000101, 4'h3, 4'hE, 4'h3, 2'b01, 1'b1, 1'b0, 0);
    run_instr("ands",   2'b00, 6'b000001, 4'h3, 4'hE, 4'h8, 2'b10, 1'b1, 1'b0, 0);
    run_instr("bcs_t",  2'b10, 6'b000000, 4'h0, 4'h2, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("bmi_t",  2'b10, 6'b000000, 4'h0, 4'h4, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("bge_t",  2'b10, 6'b000000, 4'h0, 4'hA, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("blt_nt", 2'b10, 6'b000000, 4'h0, 4'hB, 4'h0, 2'b00, 1'b0, 1'b0, 0);
    run_instr("illegal",2'b11, 6'b000001, 4'hF, 4'hE, 4'hF, 2'b00, 1'b0, 1'b0, 0);
    run_instr("subs_z2",2'b00, 6'b000101, 4'h3, 4'hE, 4'h4, 2'b01, 1'b1, 1'b0, 0);

    // Abort a store while it is in MEMWR.
    run_instr("str_rst",2'b01, 6'b011000, 4'h2, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 4);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("rst_async", {13'b0, MemWrite, RegWrite, IRWrite, PCWrite}, {13'b0, 4'b0011});
    hold_reset("rst_mid_fetch");
    run_instr("beq_rst",2'b10, 6'b000000, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 0);

`ifdef MULTICYCLE_CONTROLLER_CMP_EN
    run_instr("cmp",    2'b00, 6'b010100, 4'h0, 4'hE, 4'h6, 2'b01, 1'b1, 1'b1, 0);
    run_instr("beq_cmp",2'b10, 6'b000000, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 0);
    run_instr("bhi_cmp",2'b10, 6'b000000, 4'h0, 4'h8, 4'h0, 2'b00, 1'b0, 1'b0, 0);
`else
    run_instr("cmp_off",2'b00, 6'b010100, 4'h0, 4'hE, 4'h6, 2'b00, 1'b1, 1'b0, 0);
    run_instr("beq_off",2'b10, 6'b000000, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 0);
    run_instr("bhi_off",2'b10, 6'b000000, 4'h0, 4'h8, 4'h0, 2'b00, 1'b0, 1'b0, 0);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
